// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial sequence detector with match pulse, saturating counter and history LEDs; SEQ_DET_MASK_EN adds a loadable don't-care mask
module seq_detector_param #(
  parameter int WIDTH = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b101011,
  parameter int CNT_W = 8
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [WIDTH-1:0] pat_mask_in,
`endif
  output logic             z,
  output logic [WIDTH-1:0] leds,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  logic [WIDTH-1:0] pattern, mask, leds_next;
  logic [FW-1:0] fill, fill_inc, fill_d;
  logic hit;
`ifdef SEQ_DET_MASK_EN
  // mask is loaded together with the pattern; all ones gives an exact compare
  always_ff @(posedge system_clk)
    if (reset) mask <= '1;
    else if (pat_load) mask <= pat_mask_in;
`else
  assign mask = '1;
`endif
  // candidate history, saturating fill and match decision for the current strobe
  always_comb begin
    leds_next = {leds[WIDTH-2:0], x};
    fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    hit = (fill_inc == FULL) && (((leds_next ^ pattern) & mask) == '0);
    fill_d = pat_load ? '0 : !bit_valid ? fill : (hit && !overlap) ? '0 : fill_inc;
  end
  // state update: reset, then pattern load, then strobe, otherwise hold with z cleared
  always_ff @(posedge system_clk) begin
    if (reset) begin
      leds <= '0;
      fill <= '0;
      armed <= 1'b0;
      z <= 1'b0;
      match_count <= '0;
      pattern <= PATTERN;
    end else begin
      fill <= fill_d;
      armed <= (fill_d == FULL);
      z <= !pat_load && bit_valid && hit;
      if (pat_load) pattern <= pat_in;
      else if (bit_valid) begin
        leds <= leds_next;
        if (hit && !(&match_count)) match_count <= match_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and randomized checks of seq_detector_param against a bit-history reference model
module tb_seq_detector_param;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, bit_valid = 0, x = 0, overlap = 1, pat_load = 0;
  logic [5:0] pat_in = '0, pat_mask_in = '1;
  logic z, armed, z2, armed2;
  logic [5:0] leds, leds2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int checks = 0, failures = 0;
  bit q[$];
  int since, mcnt, mcnt2;
  logic [5:0] mpat, mmask;
  bit ez;

  seq_detector_param dut (
    .system_clk(clk), .reset(reset), .bit_valid(bit_valid), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .z(z), .leds(leds), .armed(armed), .match_count(cnt));

  seq_detector_param #(.CNT_W(2)) dut2 (
    .system_clk(clk), .reset(reset), .bit_valid(bit_valid), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .z(z2), .leds(leds2), .armed(armed2), .match_count(cnt2));

  function automatic logic [5:0] hist();
    logic [5:0] h = '0;
    for (int i = 0; i < 6; i++) if (i < q.size()) h[i] = q[q.size()-1-i];
    return h;
  endfunction

  task automatic tick(bit v, bit b, bit ld, logic [5:0] p, logic [5:0] m);
    bit_valid = v; x = b; pat_load = ld; pat_in = p; pat_mask_in = m;
    @(posedge clk);
    if (reset) begin
      q.delete(); since = 0; mpat = 6'b101011; mmask = '1; mcnt = 0; mcnt2 = 0; ez = 0;
    end else if (ld) begin
      mpat = p; since = 0; ez = 0;
`ifdef SEQ_DET_MASK_EN
      mmask = m;
`endif
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 6) void'(q.pop_front());
      since++;
      ez = since >= 6 && ((hist() ^ mpat) & mmask) == 6'b0;
      if (ez) begin
        mcnt = mcnt < 255 ? mcnt + 1 : 255;
        mcnt2 = mcnt2 < 3 ? mcnt2 + 1 : 3;
        if (!overlap) since = 0;
      end
    end else ez = 0;
    #1;
    bit_valid = 0; pat_load = 0;
  endtask

  task automatic strobe(bit b); tick(1, b, 0, '0, '1); endtask
  task automatic load(logic [5:0] p, logic [5:0] m); tick(0, 0, 1, p, m); endtask
  task automatic do_reset(); reset = 1; tick(0, 0, 0, '0, '1); reset = 0; endtask

  task automatic test_reset();
    do_reset();
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", z); end
    checks++; if (leds !== 6'b0) begin failures++; $display("FAIL reset_leds got=%b exp=000000", leds); end
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
  endtask

  task automatic test_default();
    bit s[6] = '{1, 0, 1, 0, 1, 1};
    do_reset(); overlap = 1;
    for (int i = 0; i < 6; i++) begin
      strobe(s[i]);
      checks++; if (z !== (i == 5)) begin failures++; $display("FAIL default_z%0d got=%b exp=%b", i, z, i == 5); end
    end
    checks++; if (leds !== 6'b101011) begin failures++; $display("FAIL default_leds got=%b exp=101011", leds); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL default_count got=%0d exp=1", cnt); end
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL default_armed got=%b exp=1", armed); end
    tick(0, 0, 0, '0, '1);
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL default_idle_z got=%b exp=0", z); end
  endtask

  task automatic test_overlap();
    bit s[9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
    for (int ov = 0; ov < 2; ov++) begin
      do_reset(); overlap = ov[0];
      load(6'b101101, '1);
      for (int i = 0; i < 9; i++) begin
        bit e;
        strobe(s[i]);
        e = (i == 5) || (ov == 1 && i == 8);
        checks++; if (z !== e) begin failures++; $display("FAIL overlap%0d_z%0d got=%b exp=%b", ov, i, z, e); end
      end
      checks++; if (cnt !== 8'(ov + 1)) begin failures++; $display("FAIL overlap%0d_count got=%0d exp=%0d", ov, cnt, ov + 1); end
    end
    overlap = 1;
  endtask

  task automatic test_fill_gating();
    bit s[5] = '{1, 0, 1, 0, 1};
    logic [5:0] pats[2] = '{6'b001011, 6'b010101};
    for (int k = 0; k < 2; k++) begin
      do_reset(); load(pats[k], '1);
      for (int i = 0; i < 5; i++) begin
        strobe(s[i]);
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL gating%0d_z%0d got=%b exp=0", k, i, z); end
      end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL gating%0d_armed got=%b exp=0", k, armed); end
      checks++; if (leds !== 6'b010101) begin failures++; $display("FAIL gating%0d_leds got=%b exp=010101", k, leds); end
    end
  endtask

  task automatic test_collision();
    bit s[9] = '{0, 1, 1, 1, 0, 1, 0, 1, 1};
    do_reset(); overlap = 1;
    strobe(1); strobe(0); strobe(1);
    tick(1, 1, 1, 6'b101011, '1);
    checks++; if (leds !== 6'b000101) begin failures++; $display("FAIL collide_leds got=%b exp=000101", leds); end
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL collide_armed got=%b exp=0", armed); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL collide_z got=%b exp=0", z); end
    for (int i = 0; i < 9; i++) begin
      strobe(s[i]);
      checks++; if (z !== (i == 8)) begin failures++; $display("FAIL collide_after_z%0d got=%b exp=%b", i, z, i == 8); end
    end
  endtask

  task automatic test_saturation();
    do_reset(); overlap = 1;
    load(6'b111111, '1);
    for (int i = 0; i < 10; i++) begin
      int e2 = i < 5 ? 0 : (i - 4 > 3 ? 3 : i - 4);
      strobe(1);
      checks++; if (z2 !== (i >= 5)) begin failures++; $display("FAIL sat_z%0d got=%b exp=%b", i, z2, i >= 5); end
      checks++; if (cnt2 !== 2'(e2)) begin failures++; $display("FAIL sat_count2_%0d got=%0d exp=%0d", i, cnt2, e2); end
    end
    checks++; if (cnt !== 8'd5) begin failures++; $display("FAIL sat_count8 got=%0d exp=5", cnt); end
  endtask

  task automatic test_mask();
    bit s[6] = '{1, 0, 1, 1, 0, 1};
    bit e;
`ifdef SEQ_DET_MASK_EN
    e = 1;
`else
    e = 0;
`endif
    do_reset(); overlap = 1;
    load(6'b100001, 6'b100001);
    foreach (s[i]) strobe(s[i]);
    checks++; if (z !== e) begin failures++; $display("FAIL mask_z got=%b exp=%b", z, e); end
    checks++; if (leds !== 6'b101101) begin failures++; $display("FAIL mask_leds got=%b exp=101101", leds); end
  endtask

  task automatic test_midreset();
    do_reset();
    strobe(1); strobe(0); strobe(1); strobe(0);
    do_reset();
    strobe(1); strobe(0);
    checks++; if (armed !== 1'b0) begin failures++; $display("FAIL midreset_armed got=%b exp=0", armed); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL midreset_z got=%b exp=0", z); end
    checks++; if (leds !== 6'b000010) begin failures++; $display("FAIL midreset_leds got=%b exp=000010", leds); end
  endtask

  task automatic test_random();
    bit lx = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else if (r < 6) begin
        int k = $urandom_range(0, 2);
        logic [5:0] p = k == 0 ? 6'b111111 : k == 1 ? 6'b000000 : 6'($urandom);
        load(p, 6'($urandom) | 6'b111110);
      end else if (r < 12) begin
        overlap = ~overlap;
        tick(0, 0, 0, '0, '1);
      end else if (r < 150) begin
        if ($urandom_range(0, 99) < 20) lx = ~lx;
        strobe(lx);
      end else tick(0, 0, 0, '0, '1);
      checks++; if (z !== ez) begin failures++; $display("FAIL rand_z n=%0d got=%b exp=%b", n, z, ez); end
      checks++; if (leds !== hist()) begin failures++; $display("FAIL rand_leds n=%0d got=%b exp=%b", n, leds, hist()); end
      checks++; if (armed !== (since >= 6)) begin failures++; $display("FAIL rand_armed n=%0d got=%b exp=%b", n, armed, since >= 6); end
      checks++; if (cnt !== 8'(mcnt)) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, cnt, mcnt); end
      checks++; if (cnt2 !== 2'(mcnt2)) begin failures++; $display("FAIL rand_count2 n=%0d got=%0d exp=%0d", n, cnt2, mcnt2); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_fill_gating();
    test_collision();
    test_saturation();
    test_mask();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial-bit sequence detector; successor to the fixed 6-bit LED-history detector on the lab board.
- Samples serial input `x` on a one-cycle strobe from the upstream button debouncer; the block does not clock on the button itself.
- Compares the last WIDTH bits against a run-time loadable pattern, with overlapping and non-overlapping modes.
- Drives a match pulse, a saturating match counter and the history LEDs.

Parameters:
- WIDTH, 6, pattern/history length in bits (2..16).
- PATTERN, 6'b101011, pattern register value after reset (WIDTH bits).
- CNT_W, 8, match counter width.

Ports:
- system_clk  in  1  system clock, the single clock of the block
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of system_clk
- bit_valid  in  1  one-cycle strobe; x is sampled when high
- x  in  1  serial data bit
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- pat_load  in  1  load pat_in into the pattern register
- pat_in  in  WIDTH  new pattern value
- z  out  1  match pulse
- leds  out  WIDTH  bit history; leds[0] = newest bit
- armed  out  1  history holds WIDTH valid bits since last clear
- match_count  out  CNT_W  number of matches detected

Behaviour:
- All state changes on the rising edge of system_clk; no other clock is used.
- Reset (synchronous, highest priority) sets:
  - leds = 0, fill = 0, armed = 0, z = 0, match_count = 0
  - pattern = PATTERN
  - mask = all ones (only when SEQ_DET_MASK_EN is defined)
- Fill counter: internal, 0..WIDTH, saturates at WIDTH. armed = (fill == WIDTH), registered.
- Priority when reset is low: pat_load, then bit_valid, then idle.
- pat_load = 1:
  - pattern <= pat_in; fill <= 0; z <= 0.
  - leds and match_count are unchanged.
  - A bit_valid in the same cycle is dropped (no shift).
- bit_valid = 1, pat_load = 0:
  - leds_next = {leds[WIDTH-2:0], x}; leds <= leds_next.
  - fill_next = min(fill + 1, WIDTH).
  - hit = (fill_next == WIDTH) && (leds_next == pattern), using the masked compare when enabled.
  - z <= hit. z goes high in the same cycle the new leds value is visible, i.e. 1 cycle after the strobe edge.
  - If hit and match_count != all ones: match_count <= match_count + 1. The counter saturates at 2^CNT_W - 1.
  - If hit and overlap = 0: fill <= 0, so the next match needs WIDTH fresh bits. leds is still updated.
  - If hit and overlap = 1: fill stays WIDTH; back-to-back matches are allowed.
- Idle cycles (no pat_load, no bit_valid): z <= 0, everything else holds. z is therefore never high for more than one cycle.
- Changing overlap mid-stream takes effect at the next bit_valid evaluation.
- Reset mid-sequence discards the partial history; the first match is possible only after WIDTH new strobes.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input port pat_mask_in [WIDTH-1:0] and an internal mask register.
  - pat_load loads mask <= pat_mask_in together with the pattern.
  - Compare becomes ((leds_next ^ pattern) & mask) == 0; mask bit 0 = don't-care.
  - Mask resets to all ones.
- Undefined:
  - Port and register are absent.
  - Compare is an exact equality.

Test Plan:
- Defaults, overlap = 1: after reset, strobe x = 1,0,1,0,1,1 -> z high exactly one cycle after the 6th strobe; leds = 6'b101011; match_count = 1; armed = 1.
- Overlap vs non-overlap: pat_load 6'b101101, then feed 1,0,1,1,0,1,1,0,1:
  - overlap = 1 -> z after strobes 6 and 9, count = 2.
  - overlap = 0 -> z after strobe 6 only, count = 1.
- Fill gating: reset, then 5 strobes of 1,0,1,0,1 with pattern = 6'b001011 (history 6'b010101 partial) -> no z, armed = 0. Every case with fewer than WIDTH bits since the last clear must give z = 0.
- pat_load collision: assert pat_load and bit_valid in the same cycle -> leds unchanged, fill = 0, armed = 0, z = 0. The next match requires 6 further strobes.
- Counter saturation: CNT_W = 2, overlap = 1, pattern = 6'b111111, feed 10 ones -> count goes 1,2,3,3,3; z pulses on strobes 6..10.
- SEQ_DET_MASK_EN: pattern = 6'b100001, mask = 6'b100001, stream 1,0,1,1,0,1 -> z = 1. Same stream without the macro -> z = 0.
- Mid-run reset: reset after 4 strobes of the default pattern, then strobe 1,0 -> armed = 0, z = 0, leds = 6'b000010.
